ether_rx_frame_checker: RTL and testbench

GMII-side receive frame checker, the receive-end counterpart of the Ethernet TX test path. It runs in the receive clock domain (125 MHz `ether0_clk`/`ether1_clk` class). It strips preamble, SFD and FCS, streams the payload bytes out, and verifies FCS (CRC-32), length and PHY error. It produces a per-frame status pulse and good/bad frame counters for the evaluation bench and for ILA/register readout.

---
 rtl/ether_rx_frame_checker.sv | 161 ++++++++++++++++
 tb/tb_ether_rx_frame_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD/FCS, streams payload, checks CRC/length/rx_er; payload lags input by 5 bytes.
// No backpressure: the payload sink must accept every beat, status/counters update on the tlast cycle.
module ether_rx_frame_checker #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [7:0]  m_axi4s_tdata,
   output logic        m_axi4s_tvalid,
   output logic        m_axi4s_tfirst,
   output logic        m_axi4s_tlast,
   output logic        m_axi4s_tuser,
   output logic        m_stat_valid,
   output logic        m_stat_crc_err,
   output logic        m_stat_len_err,
   output logic        m_stat_rx_err,
   output logic [15:0] m_stat_len,
   output logic [31:0] good_count,
   output logic [31:0] bad_count
);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   state_t          state;
   logic [31:0]     crc;
   logic [15:0]     len;
   logic            rx_err_flag;
   logic [3:0][7:0] hold;
   logic [2:0]      hold_cnt;
   logic [7:0]      stage;
   logic            stage_vld;
   logic            stage_first;

   logic crc_bad, len_bad, frame_bad;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Residue check: CRC run across payload and FCS, no final inversion.
   assign crc_bad   = (crc != CRC_RESIDUE);
   assign len_bad   = (len < MIN_LEN) || (len > MAX_LEN);
   assign frame_bad = crc_bad | len_bad | rx_err_flag;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state          <= IDLE;
         crc            <= '0;
         len            <= '0;
         rx_err_flag    <= 1'b0;
         hold           <= '0;
         hold_cnt       <= '0;
         stage          <= '0;
         stage_vld      <= 1'b0;
         stage_first    <= 1'b0;
         m_axi4s_tdata  <= '0;
         m_axi4s_tvalid <= 1'b0;
         m_axi4s_tfirst <= 1'b0;
         m_axi4s_tlast  <= 1'b0;
         m_axi4s_tuser  <= 1'b0;
         m_stat_valid   <= 1'b0;
         m_stat_crc_err <= 1'b0;
         m_stat_len_err <= 1'b0;
         m_stat_rx_err  <= 1'b0;
         m_stat_len     <= '0;
         good_count     <= '0;
         bad_count      <= '0;
      end else begin
         m_axi4s_tdata  <= '0;
         m_axi4s_tvalid <= 1'b0;
         m_axi4s_tfirst <= 1'b0;
         m_axi4s_tlast  <= 1'b0;
         m_axi4s_tuser  <= 1'b0;
         m_stat_valid   <= 1'b0;
         m_stat_crc_err <= 1'b0;
         m_stat_len_err <= 1'b0;
         m_stat_rx_err  <= 1'b0;
         m_stat_len     <= '0;

         case (state)
            IDLE: begin
               if (gmii_rx_dv)
                  state <= (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
               if (!gmii_rx_dv) begin
                  state <= IDLE;
               end else if (gmii_rxd == 8'hD5) begin
                  state       <= DATA;
                  crc         <= 32'hFFFFFFFF;
                  len         <= '0;
                  rx_err_flag <= 1'b0;
                  hold_cnt    <= '0;
                  stage_vld   <= 1'b0;
                  stage_first <= 1'b1;
               end else if (gmii_rxd != 8'h55) begin
                  state <= DROP;
               end
            end
            DATA: begin
               if (gmii_rx_dv) begin
                  crc  <= crc_step(crc, gmii_rxd);
                  hold <= {gmii_rxd, hold[3:1]};
                  if (len != 16'hFFFF)
                     len <= len + 16'd1;
                  if (gmii_rx_er)
                     rx_err_flag <= 1'b1;
                  // Once four bytes are held, every new byte pushes the oldest into the output stage.
                  if (hold_cnt == 3'd4) begin
                     stage     <= hold[0];
                     stage_vld <= 1'b1;
                     if (stage_vld) begin
                        m_axi4s_tvalid <= 1'b1;
                        m_axi4s_tdata  <= stage;
                        m_axi4s_tfirst <= stage_first;
                        stage_first    <= 1'b0;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 3'd1;
                  end
               end else begin
                  state     <= IDLE;
                  stage_vld <= 1'b0;
                  if (stage_vld) begin
                     m_axi4s_tvalid <= 1'b1;
                     m_axi4s_tdata  <= stage;
                     m_axi4s_tfirst <= stage_first;
                     m_axi4s_tlast  <= 1'b1;
                     m_axi4s_tuser  <= frame_bad;
                  end
                  m_stat_valid   <= 1'b1;
                  m_stat_crc_err <= crc_bad;
                  m_stat_len_err <= len_bad;
                  m_stat_rx_err  <= rx_err_flag;
                  m_stat_len     <= len;
                  good_count     <= good_count + {31'd0, ~frame_bad};
                  bad_count      <= bad_count + {31'd0, frame_bad};
               end
            end
            DROP: begin
               if (!gmii_rx_dv)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ether_rx_frame_checker.sv
// Bench for ether_rx_frame_checker: directed and random frames against a frame-level reference model.
module tb_ether_rx_frame_checker;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  d;
      logic        f;
      logic        l;
      logic        u;
   } beat_t;
   typedef struct packed {
      logic [31:0] cyc;
      logic [15:0] len;
      logic        c;
      logic        le;
      logic        r;
      logic [31:0] good;
      logic [31:0] bad;
   } stat_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic [7:0]  gmii_rxd = '0;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic [7:0]  m_axi4s_tdata;
   logic        m_axi4s_tvalid, m_axi4s_tfirst, m_axi4s_tlast, m_axi4s_tuser;
   logic        m_stat_valid, m_stat_crc_err, m_stat_len_err, m_stat_rx_err;
   logic [15:0] m_stat_len;
   logic [31:0] good_count, bad_count;

   ether_rx_frame_checker #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
      .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
      .m_axi4s_tfirst(m_axi4s_tfirst), .m_axi4s_tlast(m_axi4s_tlast),
      .m_axi4s_tuser(m_axi4s_tuser), .m_stat_valid(m_stat_valid),
      .m_stat_crc_err(m_stat_crc_err), .m_stat_len_err(m_stat_len_err),
      .m_stat_rx_err(m_stat_rx_err), .m_stat_len(m_stat_len),
      .good_count(good_count), .bad_count(bad_count)
   );

   always #4 aclk = ~aclk;

   int    cyc = 0;
   int    n_total = 0;
   int    n_bad = 0;
   int    idle_junk = 0;
   bit    mon_en = 0;
   int    m_good = 0;
   int    m_bad = 0;
   beat_t cap_beats[$], exp_beats[$];
   stat_t cap_stats[$], exp_stats[$];

   always @(posedge aclk) cyc++;

   // Capture every output beat and status pulse; flag any nonzero field while its valid is low.
   always @(negedge aclk) begin
      if (mon_en) begin
         if (m_axi4s_tvalid)
            cap_beats.push_back({32'(cyc), m_axi4s_tdata, m_axi4s_tfirst, m_axi4s_tlast, m_axi4s_tuser});
         else if ({m_axi4s_tdata, m_axi4s_tfirst, m_axi4s_tlast, m_axi4s_tuser} !== 11'd0)
            idle_junk++;
         if (m_stat_valid)
            cap_stats.push_back({32'(cyc), m_stat_len, m_stat_crc_err, m_stat_len_err, m_stat_rx_err, good_count, bad_count});
         else if ({m_stat_len, m_stat_crc_err, m_stat_len_err, m_stat_rx_err} !== 19'd0)
            idle_junk++;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Standard Ethernet CRC-32 (reflected, inverted in and out), processed one input bit at a time.
   function automatic logic [31:0] eth_crc(input bq_t b, input int n, input bit final_xor);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 8; k++) begin
            logic fb;
            fb = c[0] ^ b[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      return final_xor ? ~c : c;
   endfunction

   function automatic bq_t mk_frame(input bq_t p);
      bq_t         f = p;
      logic [31:0] fcs = eth_crc(p, p.size(), 1'b1);
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
      return f;
   endfunction

   function automatic bit fcs_wrong(input bq_t b);
      int n = b.size();
      if (n >= 4)
         return eth_crc(b, n - 4, 1'b1) != {b[n-1], b[n-2], b[n-3], b[n-4]};
      return eth_crc(b, n, 1'b0) != 32'hDEBB20E3;
   endfunction

   task automatic drive(input logic dv, input logic [7:0] d, input logic er);
      @(negedge aclk);
      gmii_rx_dv = dv;
      gmii_rxd   = d;
      gmii_rx_er = er;
   endtask

   task automatic model(input bq_t b, input bit er, input int sc[$], input int ec);
      int   n = b.size();
      logic ce = fcs_wrong(b);
      logic le = (n < 64) || (n > 1518);
      logic bd = ce | le | er;
      if (bd) m_bad++; else m_good++;
      if (n > 4)
         for (int i = 0; i <= n - 5; i++)
            exp_beats.push_back({32'((i < n - 5) ? sc[i+5] : ec), b[i], i == 0, i == n - 5, (i == n - 5) & bd});
      exp_stats.push_back({32'(ec), 16'(n), ce, le, er, 32'(m_good), 32'(m_bad)});
   endtask

   task automatic send_frame(input bq_t b, input int er_idx);
      int sc[$];
      int ec;
      for (int k = 0; k < 7; k++) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < b.size(); i++) begin
         drive(1'b1, b[i], i == er_idx);
         sc.push_back(cyc + 1);
      end
      drive(1'b0, 8'h00, 1'b0);
      ec = cyc + 1;
      model(b, er_idx >= 0 && er_idx < b.size(), sc, ec);
   endtask

   task automatic check_all(input string tag);
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      check({tag, "_nbeats"}, 128'(cap_beats.size()), 128'(exp_beats.size()));
      for (int i = 0; i < cap_beats.size() && i < exp_beats.size(); i++)
         check({tag, "_beat"}, 128'(cap_beats[i]), 128'(exp_beats[i]));
      check({tag, "_nstat"}, 128'(cap_stats.size()), 128'(exp_stats.size()));
      for (int i = 0; i < cap_stats.size() && i < exp_stats.size(); i++)
         check({tag, "_stat"}, 128'(cap_stats[i]), 128'(exp_stats[i]));
      check({tag, "_good"}, 128'(good_count), 128'(m_good));
      check({tag, "_bad"}, 128'(bad_count), 128'(m_bad));
      cap_beats.delete(); exp_beats.delete();
      cap_stats.delete(); exp_stats.delete();
   endtask

   function automatic bq_t inc_payload(input int n);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'(i));
      return p;
   endfunction

   function automatic bq_t rnd_payload(input int n);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
      return p;
   endfunction

   initial begin
      bq_t b;
      #3 aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_tvalid", 128'(m_axi4s_tvalid), 128'd0);
      check("rst_stat", 128'({m_stat_valid, m_stat_len}), 128'd0);
      check("rst_cnt", 128'({good_count, bad_count}), 128'd0);
      aresetn = 1'b1;
      mon_en = 1;
      drive(1'b0, 8'h00, 1'b0);

      // Good 64-byte frame with incrementing payload.
      send_frame(mk_frame(inc_payload(60)), -1);
      check_all("t1");
      check("t1_good_const", 128'(good_count), 128'd1);

      // Last FCS byte corrupted.
      b = mk_frame(inc_payload(60));
      b[63] = b[63] ^ 8'h01;
      send_frame(b, -1);
      check_all("t2");
      check("t2_bad_const", 128'(bad_count), 128'd1);

      // Runt with payload, then a 3-byte fragment with no payload beat.
      send_frame(mk_frame(rnd_payload(16)), -1);
      check_all("t3a");
      b = rnd_payload(3);
      send_frame(b, -1);
      check_all("t3b");

      // rx_er on data byte 10.
      send_frame(mk_frame(inc_payload(60)), 10);
      check_all("t4");

      // Length boundaries.
      send_frame(mk_frame(rnd_payload(59)), -1);
      send_frame(mk_frame(rnd_payload(1514)), -1);
      send_frame(mk_frame(rnd_payload(1515)), -1);
      send_frame(mk_frame(rnd_payload(1)), -1);
      check_all("bound");

      // Reset in the middle of a frame; the remainder must be dropped silently.
      b = mk_frame(inc_payload(60));
      for (int k = 0; k < 7; k++) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < b.size(); i++) begin
         drive(1'b1, b[i], 1'b0);
         if (i == 31) begin
            #2 aresetn = 1'b0;
            #1;
            cap_beats.delete(); exp_beats.delete();
            cap_stats.delete(); exp_stats.delete();
            m_good = 0;
            m_bad = 0;
         end
         if (i == 32) begin
            check("t5_rst_out", 128'({m_axi4s_tvalid, m_stat_valid}), 128'd0);
            check("t5_rst_cnt", 128'({good_count, bad_count}), 128'd0);
         end
         if (i == 33) #2 aresetn = 1'b1;
      end
      drive(1'b0, 8'h00, 1'b0);
      check_all("t5_drop");
      send_frame(mk_frame(inc_payload(60)), -1);
      check_all("t5_good");

      // Back-to-back good frames with a one-cycle gap, then an aborted preamble.
      send_frame(mk_frame(rnd_payload(60)), -1);
      send_frame(mk_frame(rnd_payload(60)), -1);
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h12, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check_all("t6");

      // Random frames: random lengths, occasional corrupted byte or rx_er.
      for (int r = 0; r < 10; r++) begin
         int er;
         b = mk_frame(rnd_payload($urandom_range(0, 90)));
         if ($urandom_range(0, 3) == 0) begin
            int j = $urandom_range(0, b.size() - 1);
            b[j] = b[j] ^ 8'(1 << $urandom_range(0, 7));
         end
         er = ($urandom_range(0, 4) == 0) ? $urandom_range(0, b.size() - 1) : -1;
         send_frame(b, er);
         repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'b0);
      end
      check_all("rnd");

      check("idle_zero", 128'(idle_junk), 128'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
